sar_bit_sequencer: RTL

Parametrised successor to the one-hot bit-steering demux in the ADC path. It sequences a successive-approximation conversion on its own: it walks a one-hot bit pointer from MSB to LSB and waits a programmable settling time per bit. It samples the comparator into the selected bit and presents the running DAC trial code. It sits between the comparator output and the capacitive/resistive DAC drive, with a start/done handshake toward the ADC control logic.

---
 rtl/sar_pkg.sv | 14 +
 rtl/sar_bit_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation bit sequencer.
package sar_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } sar_state_t;

  // One-hot pattern with only bit (nbits-1) set; callers narrow to their width.
  function automatic logic [15:0] msb_onehot(input int unsigned nbits);
    msb_onehot = 16'h0001 << (nbits - 1);
  endfunction

endpackage

// File: rtl/sar_bit_sequencer.sv
// Successive-approximation sequencer: walks a one-hot pointer MSB->LSB,
// waits SETTLE_CYCLES per bit, latches the comparator and drives the DAC trial code.
module sar_bit_sequencer
  import sar_pkg::*;
#(
  parameter  int unsigned NBITS         = 10,
  parameter  int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [NBITS-1:0] bitctrl,
  output logic [NBITS-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  localparam logic [NBITS-1:0] MSB_ONEHOT = NBITS'(msb_onehot(NBITS));
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);

  sar_state_t       r_state,   w_state_nxt;
  logic [NBITS-1:0] r_bitctrl, w_bitctrl_nxt;
  logic [NBITS-1:0] r_work,    w_work_nxt;
  logic [NBITS-1:0] r_result,  w_result_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;
  logic [NBITS-1:0] w_decided;

  // Working code with the bit under test replaced by the comparator decision.
  assign w_decided = (r_work & ~r_bitctrl) | (cmp_in ? r_bitctrl : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitctrl <= '0;
      r_work    <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bitctrl <= w_bitctrl_nxt;
      r_work    <= w_work_nxt;
      r_result  <= w_result_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bitctrl_nxt = r_bitctrl;
    w_work_nxt    = r_work;
    w_result_nxt  = r_result;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = CONVERT;
          w_bitctrl_nxt = MSB_ONEHOT;
          w_work_nxt    = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      CONVERT: begin
        // Abort outranks a decision that would fall on the same edge.
        if (abort) begin
          w_state_nxt   = IDLE;
          w_bitctrl_nxt = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_work_nxt    = w_decided;
          w_cnt_nxt     = '0;
          w_bitctrl_nxt = r_bitctrl >> 1;
          if (r_bitctrl[0]) begin
            w_result_nxt = w_decided;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bitctrl_nxt = '0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  assign bitctrl = r_bitctrl;
  assign trial   = r_work | r_bitctrl;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;

endmodule
